// File: rtl/rr_arb139_ctrl.sv
// Round-robin 4-way arbiter with a registered active-low grant decode, 74x139 style.
// Optional hold extension via LOCK when RR_ARB139_LOCK_EN is defined.
module rr_arb139_ctrl #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       G_N,
   input  logic [3:0] REQ,
`ifdef RR_ARB139_LOCK_EN
   input  logic       LOCK,
`endif
   output logic [3:0] GNT_N,
   output logic [1:0] GNT_IDX,
   output logic       GNT_VLD
);

   localparam int unsigned HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      GAP
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    gnt_n_q, gnt_n_d;
   logic [1:0]    idx_q, idx_d;
   logic          vld_q, vld_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [1:0]    last_q, last_d;

   logic [1:0]    win;
   logic          lock_hold;
   logic          rel;

`ifdef RR_ARB139_LOCK_EN
   assign lock_hold = LOCK & REQ[idx_q];
`else
   assign lock_hold = 1'b0;
`endif

   // Scan LAST+1 .. LAST+4 (the last wraps back onto LAST itself)
   always_comb begin
      win = last_q;
      for (int k = 4; k >= 1; k--) begin
         if (REQ[last_q + 2'(k)]) win = last_q + 2'(k);
      end
   end

   assign rel = ~REQ[idx_q] | G_N
              | ((hold_q == HOLD_MAX) & ~lock_hold);

   always_comb begin
      state_d = state_q;
      gnt_n_d = gnt_n_q;
      idx_d   = idx_q;
      vld_d   = vld_q;
      hold_d  = hold_q;
      last_d  = last_q;
      case (state_q)
         GRANT: begin
            if (rel) begin
               state_d = GAP;
               gnt_n_d = 4'b1111;
               vld_d   = 1'b0;
               last_d  = idx_q;
            end else if (hold_q != HOLD_MAX) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            if (!G_N && |REQ) begin
               state_d = GRANT;
               gnt_n_d = ~(4'b0001 << win);
               idx_d   = win;
               vld_d   = 1'b1;
               hold_d  = HW'(1);
            end else begin
               state_d = IDLE;
               gnt_n_d = 4'b1111;
               vld_d   = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         gnt_n_q <= 4'b1111;
         idx_q   <= 2'd0;
         vld_q   <= 1'b0;
         hold_q  <= '0;
         last_q  <= 2'd3;
      end else begin
         state_q <= state_d;
         gnt_n_q <= gnt_n_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         hold_q  <= hold_d;
         last_q  <= last_d;
      end
   end

   assign GNT_N   = gnt_n_q;
   assign GNT_IDX = idx_q;
   assign GNT_VLD = vld_q;

endmodule

// File: tb/tb_rr_arb139_ctrl.sv
// Bench for rr_arb139_ctrl: directed scenarios plus random traffic
// checked against a behavioural round-robin model.
module tb_rr_arb139_ctrl;

   localparam int MH = 2;

   logic       CLK;
   logic       RESET_N;
   logic       G_N;
   logic [3:0] REQ;
   logic       LOCK;
   logic [3:0] GNT_N;
   logic [1:0] GNT_IDX;
   logic       GNT_VLD;

   int n_tests = 0;
   int n_fail  = 0;

   int m_owner;
   int m_held;
   int m_last;
   int m_idx;

   int fair_seq[13] = '{0, 0, -1, 1, 1, -1, 2, 2, -1, 3, 3, -1, 0};
   int wrap_seq[7]  = '{1, 1, -1, 3, 3, -1, 1};

   rr_arb139_ctrl #(.MAX_HOLD(MH)) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .G_N     (G_N),
      .REQ     (REQ),
`ifdef RR_ARB139_LOCK_EN
      .LOCK    (LOCK),
`endif
      .GNT_N   (GNT_N),
      .GNT_IDX (GNT_IDX),
      .GNT_VLD (GNT_VLD)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_last  = 3;
      m_idx   = 0;
   endtask

   task automatic model_step(input logic [3:0] r, input logic g,
                             input logic l);
      bit lk;
      bit rel;
      int c;
      lk = 1'b0;
      if (m_owner >= 0) begin
`ifdef RR_ARB139_LOCK_EN
         lk = l && r[m_owner];
`endif
         rel = !r[m_owner] || g || (m_held >= MH && !lk);
         if (rel) begin
            m_last  = m_owner;
            m_owner = -1;
         end else if (m_held < MH) begin
            m_held++;
         end
      end else if (!g && r != 4'b0) begin
         for (int k = 1; k <= 4; k++) begin
            c = (m_last + k) % 4;
            if (r[c]) begin
               m_owner = c;
               break;
            end
         end
         m_held = 1;
         m_idx  = m_owner;
      end
   endtask

   task automatic cyc(input logic [3:0] r, input logic g, input logic l);
      logic [3:0] e;
      REQ  = r;
      G_N  = g;
      LOCK = l;
      @(posedge CLK);
      model_step(r, g, l);
      #1;
      e = 4'b1111;
      if (m_owner >= 0) e[m_owner] = 1'b0;
      chk("gnt_n", 32'(GNT_N), 32'(e));
      chk("gnt_vld", 32'(GNT_VLD), 32'(m_owner >= 0));
      chk("gnt_idx", 32'(GNT_IDX), 32'(m_idx));
   endtask

   task automatic chk_seq(input string tag, input int v);
      if (v < 0) begin
         chk({tag, "_gap"}, 32'(GNT_VLD), 32'd0);
      end else begin
         chk({tag, "_vld"}, 32'(GNT_VLD), 32'd1);
         chk({tag, "_idx"}, 32'(GNT_IDX), 32'(v));
      end
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      #1;
      chk("rst_gnt_n", 32'(GNT_N), 32'hf);
      chk("rst_vld", 32'(GNT_VLD), 32'd0);
      chk("rst_idx", 32'(GNT_IDX), 32'd0);
      model_reset();
      @(posedge CLK);
      #1;
      RESET_N = 1'b1;
   endtask

   initial begin
      int n;
      RESET_N = 1'b0;
      REQ     = 4'b0;
      G_N     = 1'b1;
      LOCK    = 1'b0;
      model_reset();
      #12;
      do_reset();

      // Fairness with all requesters active
      for (int i = 0; i < 13; i++) begin
         cyc(4'b1111, 1'b0, 1'b0);
         chk_seq("fair", fair_seq[i]);
      end

      // Abort a grant on requester 2 via G_N
      n = 0;
      while (!(GNT_VLD && GNT_IDX == 2'd2) && n < 20) begin
         cyc(4'b1111, 1'b0, 1'b0);
         n++;
      end
      chk("find_idx2", 32'(n < 20), 32'd1);
      cyc(4'b1111, 1'b1, 1'b0);
      chk("en_abort", 32'(GNT_N), 32'hf);
      for (int i = 0; i < 5; i++) begin
         cyc(4'b1111, 1'b1, 1'b0);
         chk("en_hold", 32'(GNT_VLD), 32'd0);
      end
      cyc(4'b1111, 1'b0, 1'b0);
      chk("en_resume", 32'(GNT_IDX), 32'd3);

      // Asynchronous reset in the middle of a grant
      chk("pre_rst_vld", 32'(GNT_VLD), 32'd1);
      #2;
      do_reset();

      // Wrap and skip from LAST=3
      for (int i = 0; i < 7; i++) begin
         cyc(4'b1010, 1'b0, 1'b0);
         chk_seq("wrap", wrap_seq[i]);
      end
      for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b0, 1'b0);

      // Release on request drop
      cyc(4'b0100, 1'b0, 1'b0);
      chk("drop_g0", 32'(GNT_N), 32'hb);
      cyc(4'b0100, 1'b0, 1'b0);
      chk("drop_g1", 32'(GNT_N), 32'hb);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("drop_rel", 32'(GNT_N), 32'hf);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("drop_idle", 32'(GNT_VLD), 32'd0);

`ifdef RR_ARB139_LOCK_EN
      #2;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cyc(4'b0011, 1'b0, 1'b1);
         chk_seq("lock", 0);
      end
      cyc(4'b0011, 1'b0, 1'b0);
      chk_seq("unlock", -1);
      cyc(4'b0011, 1'b0, 1'b0);
      chk_seq("unlock", 1);
`endif

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         cyc(4'($urandom_range(0, 15)),
             1'($urandom_range(0, 9) == 0),
             1'($urandom_range(0, 1)));
         chk("at_most_one", 32'($countones(~GNT_N) <= 1), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
